instruction_memory: RTL and testbench

Word-organised, read-only instruction store for the single-cycle RISC-V core. It is addressed with byte addresses straight from the PC and returns the 32-bit instruction combinationally in the same cycle. Asynchronous reset loads the fixed boot program into the storage array. The block sits between the PC register and the instruction decoder.

---
 rtl/imem_pkg.sv | 35 +++
 rtl/instruction_memory.sv | 51 +++++
 tb/tb_instruction_memory.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared constants for the instruction store: default geometry, fill word,
// and the fixed boot program image.
package imem_pkg;

    // Default number of 32-bit words (address span 0x000-0x0FC).
    localparam int unsigned IMEM_DEPTH = 64;

    // Fill value for every word outside the boot program: addi x0,x0,0.
    localparam logic [31:0] IMEM_NOP_WORD = 32'h00000013;

    // RV32I R-type opcode; every word of the boot program uses it.
    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

    // Number of words occupied by the boot program.
    localparam int unsigned BOOT_LEN = 8;

    // Boot image lookup by word index; words past the program return fill.
    function automatic logic [31:0] boot_word(input int unsigned idx,
                                              input logic [31:0] fill);
        logic [31:0] word;
        case (idx)
            0:       word = 32'h002081B3; // add  x3,x1,x2
            1:       word = 32'h40208233; // sub  x4,x1,x2
            2:       word = 32'h0020F2B3; // and  x5,x1,x2
            3:       word = 32'h0020E333; // or   x6,x1,x2
            4:       word = 32'h0020C3B3; // xor  x7,x1,x2
            5:       word = 32'h00209433; // sll  x8,x1,x2
            6:       word = 32'h0020D4B3; // srl  x9,x1,x2
            7:       word = 32'h0020A533; // slt  x10,x1,x2
            default: word = fill;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Read-only, word-organised instruction store. Byte-addressed from the PC,
// combinational read, contents loaded with the boot image by async reset.
// There is no handshake: the output is valid whenever reset is low, with
// zero latency from read_address.
module instruction_memory
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH    = IMEM_DEPTH,
    parameter logic [31:0] NOP_WORD = IMEM_NOP_WORD
) (
    output logic [31:0] Instruction_out,
    input  logic [31:0] read_address,
    input  logic        clk,
    input  logic        reset
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [31:0]      mem [0:DEPTH-1];
    logic [IDX_W-1:0] word_idx;
    logic             out_of_range;
    logic             unused_byte_offset;

    // Byte offset within a word is ignored: misaligned reads return the
    // enclosing aligned word.
    assign word_idx           = read_address[IDX_W+1:2];
    assign out_of_range       = |read_address[31:IDX_W+2];
    assign unused_byte_offset = ^read_address[1:0];

    // Load the boot image while reset is high; no write port, so the
    // contents hold on every other clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= boot_word(i, NOP_WORD);
            end
        end
    end

    // Combinational read: zero during reset, fill word above the array,
    // otherwise the addressed word (no wrap-around).
    always_comb begin
        Instruction_out = NOP_WORD;
        if (reset) begin
            Instruction_out = 32'h00000000;
        end else if (!out_of_range) begin
            Instruction_out = mem[word_idx];
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Bench for instruction_memory: directed and random reads, expected words
// from a reference image, checked by a monitor popping a scoreboard queue.
module tb_instruction_memory;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [31:0] read_address;
    logic [31:0] Instruction_out;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    string       name_q[$];
    event        sample_ev;

    logic [31:0] image [0:63];

    instruction_memory dut (
        .Instruction_out (Instruction_out),
        .read_address    (read_address),
        .clk             (clk),
        .reset           (reset)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model(input logic [31:0] addr, input logic rst);
        if (rst) return 32'h00000000;
        if (addr > 32'h000000FF) return NOP;
        return image[addr / 4];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_now(input string name);
        exp_q.push_back(model(read_address, reset));
        addr_q.push_back(read_address);
        name_q.push_back(name);
        -> sample_ev;
        #2;
    endtask

    task automatic read_word(input logic [31:0] addr, input string name);
        read_address = addr;
        check_now(name);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [31:0] exp;
        logic [31:0] addr;
        string       name;
        forever begin
            @(sample_ev);
            #1;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard_empty: output %h with no expected entry", Instruction_out);
            end else begin
                exp  = exp_q.pop_front();
                addr = addr_q.pop_front();
                name = name_q.pop_front();
                if (Instruction_out !== exp) begin
                    tests_failed++;
                    $display("FAIL %s: addr=%h reset=%b got %h expected %h",
                             name, addr, reset, Instruction_out, exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int          wait_cycles;

        for (int i = 0; i < 64; i++) image[i] = NOP;
        image[0] = 32'h002081B3;
        image[1] = 32'h40208233;
        image[2] = 32'h0020F2B3;
        image[3] = 32'h0020E333;
        image[4] = 32'h0020C3B3;
        image[5] = 32'h00209433;
        image[6] = 32'h0020D4B3;
        image[7] = 32'h0020A533;

        // Reset for 10 ns, output must be zero meanwhile.
        reset        = 1'b1;
        read_address = 32'h0;
        #2;
        check_now("during_reset");
        #6;
        reset = 1'b0;
        read_address = 32'h0;
        check_now("first_word");

        // Sequential sweep, one word every 20 ns.
        for (int i = 1; i < 8; i++) begin
            #18;
            read_word(32'(i * 4), "sweep");
        end

        // Misaligned, unprogrammed, and out-of-range addresses.
        read_word(32'h05, "misaligned_05");
        read_word(32'h06, "misaligned_06");
        read_word(32'h07, "misaligned_07");
        read_word(32'h20, "unprogrammed_20");
        read_word(32'hFC, "last_word_fc");
        read_word(32'hFF, "last_word_ff");
        read_word(32'h100, "out_of_range_100");
        read_word(32'hFFFFFFFC, "out_of_range_top");
        read_word(32'h104, "no_wrap_104");

        // Reset pulse between clock edges with read_address = 0x10.
        read_word(32'h10, "pre_pulse");
        @(posedge clk);
        #2;
        reset = 1'b1;
        check_now("mid_reset_zero");
        reset = 1'b0;
        check_now("after_pulse");

        // Address change coincident with a rising edge.
        @(posedge clk);
        read_address = 32'h0C;
        check_now("edge_change");
        @(posedge clk);
        read_address = 32'h18;
        check_now("edge_change2");

        // Randomized reads, with occasional reset pulses.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 31));
                1:       a = 32'($urandom_range(0, 255));
                2:       a = 32'($urandom_range(256, 1023));
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                read_word(a, "rand_in_reset");
                reset = 1'b0;
            end
            read_word(a, "rand_read");
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end

        // Drain the scoreboard within a bounded wait.
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 100) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
